// File: rtl/priority_encoder.sv
// Registered highest-index-wins priority encoder.
// Reduces a WIDTH-bit request vector to the index of its most significant set
// bit, with a matching one-hot grant and a valid flag. All outputs come
// straight from flops; en=0 holds them, rst clears them and overrides en.
module priority_encoder #(
    parameter int WIDTH = 4,
    parameter int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic [WIDTH-1:0] onehot
);

    // Reject configurations that cannot address every request or fall
    // outside the supported range.
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("priority_encoder: WIDTH must be in 2..64");
    end
    if (OUT_W < 1 || (2 ** OUT_W) < WIDTH) begin : g_bad_out_w
        $error("priority_encoder: OUT_W too narrow for WIDTH");
    end

    logic [OUT_W-1:0] enc_idx;
    logic             enc_hit;
    logic [WIDTH-1:0] enc_oh;

    logic [OUT_W-1:0] out_d,    out_q;
    logic             valid_d,  valid_q;
    logic [WIDTH-1:0] onehot_d, onehot_q;

    // Scan upward from bit 0; a later (higher) hit overrides an earlier one,
    // so the last assignment is the highest set bit. The one-hot is rebuilt
    // per hit, so the grant only ever names an index below WIDTH.
    always_comb begin
        enc_idx = '0;
        enc_hit = 1'b0;
        enc_oh  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                enc_idx   = OUT_W'(i);
                enc_hit   = 1'b1;
                enc_oh    = '0;
                enc_oh[i] = 1'b1;
            end
        end
    end

    // Next-state: capture the fresh encode when enabled, otherwise hold.
    always_comb begin
        out_d    = out_q;
        valid_d  = valid_q;
        onehot_d = onehot_q;
        if (en) begin
            out_d    = enc_idx;
            valid_d  = enc_hit;
            onehot_d = enc_oh;
        end
    end

    // Output registers; synchronous reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            valid_q  <= 1'b0;
            onehot_q <= '0;
        end else begin
            out_q    <= out_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
        end
    end

    assign out    = out_q;
    assign valid  = valid_q;
    assign onehot = onehot_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder: three configurations (4/2, 8/3, 5/3) share
// clk/rst/en. A behavioural model tracks the expected highest-set-bit index
// per instance; a negedge process compares every output each cycle, and the
// stimulus sequence pins the model with hand-computed literal results.
module tb_priority_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] in4 = '0;
    logic [7:0] in8 = '0;
    logic [4:0] in5 = '0;

    logic [1:0] o4;  logic v4;  logic [3:0] oh4;
    logic [2:0] o8;  logic v8;  logic [7:0] oh8;
    logic [2:0] o5;  logic v5;  logic [4:0] oh5;

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  checking = 1'b0;
    int  e_idx [3];

    priority_encoder #(.WIDTH(4), .OUT_W(2)) dut4 (
        .clk(clk), .rst(rst), .en(en), .in(in4), .out(o4), .valid(v4), .onehot(oh4));
    priority_encoder #(.WIDTH(8), .OUT_W(3)) dut8 (
        .clk(clk), .rst(rst), .en(en), .in(in8), .out(o8), .valid(v8), .onehot(oh8));
    priority_encoder #(.WIDTH(5), .OUT_W(3)) dut5 (
        .clk(clk), .rst(rst), .en(en), .in(in5), .out(o5), .valid(v5), .onehot(oh5));

    // Index of the most significant set bit, -1 when none.
    function automatic int msb_of(logic [63:0] v, int w);
        for (int i = w - 1; i >= 0; i--)
            if (v[i]) return i;
        return -1;
    endfunction

    // Model: -1 encodes "no valid result"; reset clears, en captures.
    always @(posedge clk) begin
        if (rst) begin
            e_idx <= '{-1, -1, -1};
        end else if (en) begin
            e_idx[0] <= msb_of(64'(in4), 4);
            e_idx[1] <= msb_of(64'(in8), 8);
            e_idx[2] <= msb_of(64'(in5), 5);
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(string tag, int w, int ei, logic [63:0] o, logic v, logic [63:0] oh);
        logic        ev;
        logic [63:0] eo, eoh;
        ev  = (ei >= 0);
        eo  = ev ? 64'(ei) : 64'd0;
        eoh = ev ? (64'd1 << ei) : 64'd0;
        chk({tag, ".out"},    o,  eo);
        chk({tag, ".valid"},  64'(v), 64'(ev));
        chk({tag, ".onehot"}, oh, eoh);
        chk({tag, ".inv_onehot"}, oh, v ? (64'd1 << o) : 64'd0);
        chk({tag, ".range"}, 64'(o < 64'(w)), 64'd1);
    endtask

    // Per-cycle scoreboard comparison, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            cmp_inst("w4", 4, e_idx[0], 64'(o4), v4, 64'(oh4));
            cmp_inst("w8", 8, e_idx[1], 64'(o8), v8, 64'(oh8));
            cmp_inst("w5", 5, e_idx[2], 64'(o5), v5, 64'(oh5));
        end
    end

    // Apply inputs, let one edge capture them, settle just after the edge.
    task automatic step(bit r, bit e, logic [3:0] a, logic [7:0] b, logic [4:0] c);
        rst = r; en = e; in4 = a; in8 = b; in5 = c;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] dir_in  [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b1111, 4'b0100};
    logic [1:0] dir_out [5] = '{2'd0,    2'd0,    2'd1,    2'd3,    2'd2};
    logic       dir_v   [5] = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b1};
    logic [3:0] dir_oh  [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b0100};

    initial begin
        // Reset held 3 cycles with all requests active.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 4'b1111, 8'hff, 5'h1f);
            checking = 1'b1;
            chk("rst.out4",    64'(o4),  64'd0);
            chk("rst.valid4",  64'(v4),  64'd0);
            chk("rst.onehot4", 64'(oh4), 64'd0);
            chk("rst.valid8",  64'(v8),  64'd0);
        end
        step(1'b0, 1'b1, 4'b1111, 8'h80, 5'b10101);
        chk("rel.out4",    64'(o4),  64'd3);
        chk("rel.valid4",  64'(v4),  64'd1);
        chk("sweep.out8",  64'(o8),  64'd7);
        chk("sweep.out5",  64'(o5),  64'd4);
        chk("sweep.oh5",   64'(oh5), 64'b10000);

        // Directed vectors.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, dir_in[i], 8'h01, 5'b00011);
            chk("dir.out4",    64'(o4),  64'(dir_out[i]));
            chk("dir.valid4",  64'(v4),  64'(dir_v[i]));
            chk("dir.onehot4", 64'(oh4), 64'(dir_oh[i]));
        end
        chk("dir.out5", 64'(o5), 64'd1);

        // Exhaustive 4-bit sweep back-to-back.
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 4'(i), 8'($urandom), 5'($urandom));

        // Enable hold.
        step(1'b0, 1'b1, 4'b0110, 8'h00, 5'h00);
        chk("hold.cap_out4", 64'(o4), 64'd2);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 4'b0001, 8'hff, 5'h1f);
            chk("hold.out4",   64'(o4), 64'd2);
            chk("hold.valid4", 64'(v4), 64'd1);
            chk("hold.valid8", 64'(v8), 64'd0);
        end
        step(1'b0, 1'b1, 4'b0001, 8'h00, 5'h00);
        chk("hold.rel_out4",   64'(o4), 64'd0);
        chk("hold.rel_valid4", 64'(v4), 64'd1);

        // Mid-stream reset pulse.
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 4'($urandom), 8'($urandom), 5'($urandom));
        step(1'b1, 1'b1, 4'b1111, 8'hff, 5'h1f);
        chk("mid.valid4", 64'(v4), 64'd0);
        chk("mid.valid8", 64'(v8), 64'd0);
        chk("mid.valid5", 64'(v5), 64'd0);
        step(1'b0, 1'b1, 4'b1000, 8'h30, 5'b01001);
        chk("mid.out4", 64'(o4), 64'd3);
        chk("mid.out8", 64'(o8), 64'd5);
        chk("mid.out5", 64'(o5), 64'd3);

        // Random soak with occasional enable drops and resets.
        for (int i = 0; i < 1000; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 4'($urandom), 8'($urandom), 5'($urandom));

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_encoder.md
# priority_encoder

Registered, parameterizable highest-index-wins priority encoder. It reduces a WIDTH-bit request vector to the binary index of its most significant set bit. It also produces a one-hot grant and a valid flag. It serves as a request-to-index stage in front of arbiters, interrupt controllers and decode logic; the default configuration is the 4-to-2 encoder.

## Interface
Parameters:
- WIDTH, 4: number of request inputs; legal range 2..64.
- OUT_W, $clog2(WIDTH): index width; must be ≥ 1 and satisfy 2**OUT_W ≥ WIDTH.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock; all state updates on this edge only.
- rst  input  1  synchronous, active-high reset; sampled on rising clk edge.
- en  input  1  capture enable; when low, all outputs hold.
- in  input  WIDTH  request vector; bit i = request i; higher index = higher priority.
- out  output  OUT_W  binary index of highest set bit of the captured in.
- valid  output  1  1 when the captured in had at least one bit set.
- onehot  output  WIDTH  one-hot copy of out (bit out set); all-zero when valid=0.

## Operation
- Priority: highest index wins. out = max{i : in[i]=1}.
- Lower set bits are ignored entirely (in=0011 → index 1, not 0).
- Empty input: in=0 → out=0, valid=0, onehot=0.
  - out=0 with valid=0 is not a request for index 0; consumers must qualify out with valid.
- Consistency invariants, every cycle outside reset:
  - onehot == (valid ? 1<<out : 0).
  - popcount(onehot) ≤ 1.
  - valid == |onehot.
- Combinational core: a loop or priority chain scanning from bit 0 upward, last hit wins (or equivalent); no latches; X-free for any defined in.
- Unused index codes (WIDTH < 2**OUT_W) are never produced.
- No internal state beyond the output registers; no FSM.

## Timing
- Reset: on a rising clk with rst=1, out=0, valid=0 and onehot=0 on the next edge's output.
  - rst has priority over en.
  - Outputs stay at their reset values while rst is held.
- Latency: exactly 1 cycle. in sampled at edge N with en=1 appears on out/valid/onehot after edge N.
- en=0 at edge N: outputs keep their values from before edge N; in is ignored.
- Throughput: one new encode per cycle when en=1 continuously; no bubbles, no handshake back-pressure.
- Reset asserted mid-stream: the pending capture is discarded; the first valid result follows the first en=1 edge after rst deasserts.
- Outputs are registered directly (no combinational path from in/en to outputs).

## Test plan
- Reset: hold rst=1 for 3 cycles with in=1111, en=1 → out=00, valid=0, onehot=0000 throughout; first edge after release gives out=11, valid=1.
- Directed WIDTH=4 vectors with en=1, checked one cycle after apply:
  - 0000 → out=00 valid=0 onehot=0000
  - 0001 → out=00 valid=1 onehot=0001
  - 0011 → out=01 valid=1 onehot=0010
  - 1111 → out=11 valid=1 onehot=1000
  - 0100 → out=10 valid=1 onehot=0100
- Exhaustive WIDTH=4: all 16 inputs back-to-back, en=1 → each result matches the reference model exactly one cycle later; invariants hold every cycle.
- Enable hold: capture 0110 (out=10), then drop en and drive 0001 for 4 cycles → out stays 10, valid=1; raise en → out=00 next cycle.
- Mid-stream reset: stream random inputs, pulse rst for 1 cycle → outputs 0 the following cycle, correct results resume one cycle after the next en=1 edge.
- Parameter sweep WIDTH=8, OUT_W=3, and WIDTH=5, OUT_W=3: in=10000000 → 111; in=10101 → 100; random 1000 vectors match the model, no out value ≥ WIDTH.
